// File: rtl/present_inv_key_sched_if.sv
// Handshake bundle between the inverse key scheduler and the decrypt round pipeline.
// The consumer drives start/orig_key/rk_ready, and the scheduler drives everything else.
interface present_inv_key_sched_if #(
  parameter int KEY_SIZE = 80
);
  logic                start;
  logic [KEY_SIZE-1:0] orig_key;
  logic                busy;
  logic                rk_valid;
  logic                rk_ready;
  logic [63:0]         round_key;
  logic [5:0]          rk_index;
  logic                done;

  modport master (
    output start, orig_key, rk_ready,
    input  busy, rk_valid, round_key, rk_index, done
  );

  modport slave (
    input  start, orig_key, rk_ready,
    output busy, rk_valid, round_key, rk_index, done
  );
endinterface

// File: rtl/present_inv_key_sched.sv
// PRESENT decrypt-side key schedule: runs the forward update up to the last key,
// then walks back with the inverse update, handing out K(NUM_ROUNDS+1)..K1.
module present_inv_key_sched #(
  parameter int KEY_SIZE   = 80,
  parameter int NUM_ROUNDS = 31
) (
  input logic                   clk,
  input logic                   rst_n,
  present_inv_key_sched_if.slave bus
);

  generate
    if (KEY_SIZE != 80 && KEY_SIZE != 128) begin : g_bad_key_size
      $error("present_inv_key_sched: KEY_SIZE must be 80 or 128");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam int         XOR_LO    = (KEY_SIZE == 128) ? 62 : 15;
  localparam logic [5:0] LAST_CNT  = 6'(NUM_ROUNDS);
  localparam logic [5:0] FIRST_IDX = 6'(NUM_ROUNDS + 1);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [KEY_SIZE-1:0] fwd_step(input logic [KEY_SIZE-1:0] k,
                                                  input logic [4:0]          i);
    logic [KEY_SIZE-1:0] r;
    r = {k[KEY_SIZE-62:0], k[KEY_SIZE-1:KEY_SIZE-61]};
    r[KEY_SIZE-1 -: 4] = sbox(r[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) r[KEY_SIZE-5 -: 4] = sbox(r[KEY_SIZE-5 -: 4]);
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ i;
    return r;
  endfunction

  // Undo fwd_step in reverse order: counter XOR, S-box, then rotate right by 61.
  function automatic logic [KEY_SIZE-1:0] inv_step(input logic [KEY_SIZE-1:0] k,
                                                  input logic [4:0]          i);
    logic [KEY_SIZE-1:0] r;
    r = k;
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ i;
    r[KEY_SIZE-1 -: 4] = inv_sbox(r[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) r[KEY_SIZE-5 -: 4] = inv_sbox(r[KEY_SIZE-5 -: 4]);
    return {r[60:0], r[KEY_SIZE-1:61]};
  endfunction

  logic [1:0]          r_state;
  logic [KEY_SIZE-1:0] r_key;
  logic [5:0]          r_cnt;
  logic [5:0]          r_rk_index;
  logic                r_busy;
  logic                r_rk_valid;
  logic                r_done;

  logic                w_accept;
  logic [4:0]          w_idx_m1;
  logic [KEY_SIZE-1:0] w_fwd_key;
  logic [KEY_SIZE-1:0] w_inv_key;

  assign w_accept  = r_rk_valid & bus.rk_ready;
  assign w_idx_m1  = r_rk_index[4:0] - 5'd1;
  assign w_fwd_key = fwd_step(r_key, r_cnt[4:0]);
  assign w_inv_key = inv_step(r_key, w_idx_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_cnt      <= '0;
      r_rk_index <= '0;
      r_busy     <= 1'b0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_key   <= bus.orig_key;
            r_cnt   <= 6'd1;
            r_busy  <= 1'b1;
            r_state <= S_FWD;
          end
        end
        S_FWD: begin
          r_key <= w_fwd_key;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == LAST_CNT) begin
            r_state    <= S_EMIT;
            r_rk_index <= FIRST_IDX;
            r_rk_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          // Key K(n) was produced with counter n-1, so that is what we un-XOR.
          if (w_accept) begin
            if (r_rk_index > 6'd1) begin
              r_key      <= w_inv_key;
              r_rk_index <= r_rk_index - 6'd1;
            end else begin
              r_state    <= S_IDLE;
              r_rk_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.rk_valid  = r_rk_valid;
  assign bus.round_key = r_key[KEY_SIZE-1 -: 64];
  assign bus.rk_index  = r_rk_index;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_present_inv_key_sched.sv
// Bench for the PRESENT inverse key schedule: an 80-bit and a 128-bit instance,
// checked against a bit-level forward model whose keys are replayed in reverse.
module tb_present_inv_key_sched;
  localparam int          NR     = 31;
  localparam logic [63:0] SBOX_V = 64'hC56B90AD3EF84712;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  present_inv_key_sched_if #(.KEY_SIZE(80))  if80 ();
  present_inv_key_sched_if #(.KEY_SIZE(128)) if128 ();

  present_inv_key_sched #(.KEY_SIZE(80), .NUM_ROUNDS(NR)) dut80 (
    .clk(clk), .rst_n(rst_n), .bus(if80)
  );
  present_inv_key_sched #(.KEY_SIZE(128), .NUM_ROUNDS(NR)) dut128 (
    .clk(clk), .rst_n(rst_n), .bus(if128)
  );

  typedef struct packed {
    logic [63:0] key;
    logic [5:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [3:0] sb4(input logic [3:0] x);
    logic [63:0] t;
    t = SBOX_V;
    return t[63 - 4*int'(x) -: 4];
  endfunction

  // Forward update built bit by bit so it shares no structure with the RTL.
  function automatic logic [127:0] model_step(input logic [127:0] k, input int ks,
                                             input logic [4:0] i);
    logic [127:0] r;
    int lo;
    r = '0;
    for (int j = 0; j < ks; j++) r[(j + 61) % ks] = k[j];
    r[ks-1 -: 4] = sb4(r[ks-1 -: 4]);
    if (ks == 128) r[ks-5 -: 4] = sb4(r[ks-5 -: 4]);
    lo = (ks == 128) ? 62 : 15;
    r[lo +: 5] ^= i;
    return r;
  endfunction

  task automatic push_expected(input logic [127:0] key, input int ks);
    logic [63:0]  rk [NR+2];
    logic [127:0] st;
    st = key;
    for (int r = 1; r <= NR + 1; r++) begin
      rk[r] = 64'(st >> (ks - 64));
      st = model_step(st, ks, 5'(r));
    end
    for (int r = NR + 1; r >= 1; r--) sb.push_back('{rk[r], 6'(r)});
  endtask

  task automatic do_start(input bit w128, input logic [127:0] key);
    @(negedge clk);
    if (w128) begin
      if128.start = 1'b1; if128.orig_key = key;
    end else begin
      if80.start = 1'b1;  if80.orig_key = key[79:0];
    end
    push_expected(key, w128 ? 128 : 80);
    @(negedge clk);
    if80.start = 1'b0;
    if128.start = 1'b0;
  endtask

  // Pops the scoreboard on every handshake; optionally pokes start at a given
  // handshake count, or stops (ready low) once rk_index reaches stop_idx.
  task automatic drain(input bit w128, input int duty, input int poke_hs,
                       input int stop_idx, input string tag);
    int cyc = 0, hs = 0, dones = 0;
    bit stall = 0, poked = 0, rdy;
    logic v, d, b;
    logic [63:0] k, hk;
    logic [5:0] x, hi;
    exp_t e;
    while (sb.size() > 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if80.start = 1'b0;
      if128.start = 1'b0;
      if (poke_hs >= 0 && hs == poke_hs && !poked) begin
        poked = 1;
        if80.start = 1'b1;
        if80.orig_key = 80'({$urandom, $urandom, $urandom});
      end
      v = w128 ? if128.rk_valid  : if80.rk_valid;
      k = w128 ? if128.round_key : if80.round_key;
      x = w128 ? if128.rk_index  : if80.rk_index;
      d = w128 ? if128.done      : if80.done;
      if (d) dones++;
      if (stall && v) begin
        n_cmp++;
        if (k !== hk || x !== hi) begin
          n_bad++;
          $display("FAIL %s stall_hold: got %h/%0d required %h/%0d", tag, k, x, hk, hi);
        end
      end
      if (stop_idx > 0 && v && x == 6'(stop_idx)) begin
        if80.rk_ready = 1'b0;
        return;
      end
      rdy = ($urandom_range(0, 99) < duty);
      if (w128) if128.rk_ready = rdy; else if80.rk_ready = rdy;
      stall = v && !rdy;
      hk = k;
      hi = x;
      if (v && rdy) begin
        e = sb.pop_front();
        hs++;
        n_cmp++;
        if (k !== e.key || x !== e.idx) begin
          n_bad++;
          $display("FAIL %s round_key: got %h idx %0d required %h idx %0d", tag, k, x, e.key, e.idx);
        end
      end
    end
    if80.start = 1'b0;
    if (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: got %0d handshakes required %0d", tag, hs, hs + sb.size());
      sb.delete();
      return;
    end
    @(negedge clk);
    if80.rk_ready = 1'b0;
    if128.rk_ready = 1'b0;
    d = w128 ? if128.done : if80.done;
    v = w128 ? if128.rk_valid : if80.rk_valid;
    b = w128 ? if128.busy : if80.busy;
    n_cmp++;
    if (d !== 1'b1 || v !== 1'b0 || b !== 1'b0 || dones != 0) begin
      n_bad++;
      $display("FAIL %s done_pulse: got done=%b valid=%b busy=%b early=%0d required 1/0/0/0", tag, d, v, b, dones);
    end
    @(negedge clk);
    d = w128 ? if128.done : if80.done;
    n_cmp++;
    if (d !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_width: got %b required 0", tag, d);
    end
    n_cmp++;
    if (hs != NR + 1) begin
      n_bad++;
      $display("FAIL %s hs_count: got %0d required %0d", tag, hs, NR + 1);
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({if80.busy, if80.rk_valid, if80.done, if80.round_key, if80.rk_index} !== '0) begin
      n_bad++;
      $display("FAIL reset80: got %b%b%b %h %0d required all zero", if80.busy, if80.rk_valid, if80.done, if80.round_key, if80.rk_index);
    end
    n_cmp++;
    if ({if128.busy, if128.rk_valid, if128.done, if128.round_key, if128.rk_index} !== '0) begin
      n_bad++;
      $display("FAIL reset128: got %b%b%b %h %0d required all zero", if128.busy, if128.rk_valid, if128.done, if128.round_key, if128.rk_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_known_vector();
    int w = 0;
    do_start(0, '0);
    n_cmp++;
    if (if80.busy !== 1'b1 || if80.rk_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fwd_busy: got busy=%b valid=%b required 1/0", if80.busy, if80.rk_valid);
    end
    while (!if80.rk_valid && w < 100) begin @(negedge clk); w++; end
    n_cmp++;
    if (if80.round_key !== 64'h6DAB31744F41D700 || if80.rk_index !== 6'd32) begin
      n_bad++;
      $display("FAIL k32_zero: got %h idx %0d required 6dab31744f41d700 idx 32", if80.round_key, if80.rk_index);
    end
    drain(0, 100, -1, 0, "t1");
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 100; n++) begin
      do_start(0, 128'({$urandom, $urandom, $urandom}));
      drain(0, 100, -1, 0, "t2");
    end
  endtask

  task automatic test_backpressure();
    do_start(0, '0);
    drain(0, 30, -1, 0, "t3_zero");
    do_start(0, 128'({$urandom, $urandom, $urandom}));
    drain(0, 30, -1, 0, "t3_rand");
  endtask

  task automatic test_start_ignored();
    do_start(0, 128'(80'hFEDCBA98765432100123));
    repeat (3) @(negedge clk);
    if80.start = 1'b1;
    if80.orig_key = 80'h0123456789ABCDEF0011;
    @(negedge clk);
    if80.start = 1'b0;
    drain(0, 60, 10, 0, "t4");
  endtask

  task automatic test_reset_mid_emit();
    int seen_done = 0;
    do_start(0, 128'({$urandom, $urandom, $urandom}));
    drain(0, 100, -1, 17, "t5");
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if80.busy, if80.rk_valid, if80.done, if80.round_key, if80.rk_index} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got %b%b%b %h %0d required all zero", if80.busy, if80.rk_valid, if80.done, if80.round_key, if80.rk_index);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (if80.done || if80.busy) seen_done++;
    end
    n_cmp++;
    if (seen_done != 0) begin
      n_bad++;
      $display("FAIL no_done_after_abort: got %0d active cycles required 0", seen_done);
    end
    do_start(0, 128'({$urandom, $urandom, $urandom}));
    drain(0, 100, -1, 0, "t5_restart");
  endtask

  task automatic test_key128();
    for (int n = 0; n < 10; n++) begin
      do_start(1, {$urandom, $urandom, $urandom, $urandom});
      drain(1, 70, -1, 0, "t6");
    end
  endtask

  initial begin
    if80.start = 1'b0;  if80.orig_key = '0;  if80.rk_ready = 1'b0;
    if128.start = 1'b0; if128.orig_key = '0; if128.rk_ready = 1'b0;
    test_reset();
    test_known_vector();
    test_random_keys();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_emit();
    test_key128();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
